// File: rtl/lib_div_seq.sv
// lib_div_seq: sequential signed restoring divider with valid/ready handshakes.
// Define LIB_DIV_REM_EN to compile in the remainder output; otherwise r is tied to 0.
module lib_div_seq #(
  parameter int Na = 16,
  parameter int Nb = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [Na-1:0] a,
  input  logic [Nb-1:0] b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [Na-1:0] q,
  output logic [Nb-1:0] r,
  output logic          dbz,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int CW = $clog2(Na + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [Nb:0] p_q;
  logic [Na-1:0] aq_q, q_q;
  logic [Nb-1:0] bm_q;
  logic sq_q, dbz_q;
  logic acc, last, ge;
  logic [Na-1:0] a_abs;
  logic [Nb-1:0] b_abs;
  logic [Nb:0] t, sub;
`ifdef LIB_DIV_REM_EN
  logic [Nb-1:0] r_q;
  logic sr_q;
  assign r = r_q;
`else
  assign r = '0;
`endif
  assign acc   = in_valid && in_ready;
  assign last  = cnt_q == CW'(Na - 1);
  assign a_abs = a[Na-1] ? -a : a;
  assign b_abs = b[Nb-1] ? -b : b;
  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign t     = (Nb+1)'({p_q, aq_q[Na-1]});
  assign sub   = t - {1'b0, bm_q};
  assign ge    = t >= {1'b0, bm_q};
  assign q     = q_q;
  assign dbz   = dbz_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (in_valid ? (b == '0 ? DONE : CALC) : IDLE) :
              state_q == CALC ? (last ? FIX : CALC) :
              state_q == FIX  ? DONE :
              (out_ready ? IDLE : DONE);
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      p_q   <= '0;
      aq_q  <= '0;
      bm_q  <= '0;
      sq_q  <= 1'b0;
      q_q   <= '0;
      dbz_q <= 1'b0;
`ifdef LIB_DIV_REM_EN
      sr_q  <= 1'b0;
      r_q   <= '0;
`endif
    end else if (acc) begin
      aq_q  <= a_abs;
      bm_q  <= b_abs;
      sq_q  <= a[Na-1] ^ b[Nb-1];
      cnt_q <= '0;
      p_q   <= '0;
`ifdef LIB_DIV_REM_EN
      sr_q  <= a[Na-1];
`endif
      if (b == '0) begin
        q_q   <= '0;
        dbz_q <= 1'b1;
`ifdef LIB_DIV_REM_EN
        r_q   <= '0;
`endif
      end
    end else if (state_q == CALC) begin
      p_q   <= ge ? sub : t;
      aq_q  <= {aq_q[Na-2:0], ge};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == FIX) begin
      q_q   <= sq_q ? -aq_q : aq_q;
      dbz_q <= 1'b0;
`ifdef LIB_DIV_REM_EN
      r_q   <= sr_q ? -p_q[Nb-1:0] : p_q[Nb-1:0];
`endif
    end
endmodule

// File: tb/tb_lib_div_seq.sv
// tb_lib_div_seq: table-driven and scoreboarded checks of lib_div_seq at Na=16, Nb=8.
module tb_lib_div_seq;
  localparam int Na = 16;
  localparam int Nb = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] a = '0;
  logic [7:0] b = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, dbz;
  logic [15:0] q;
  logic [7:0] r;

  lib_div_seq #(.Na(Na), .Nb(Nb)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .r(r), .dbz(dbz), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; logic [7:0] b; logic [15:0] q; logic [7:0] r; logic d; int hold;} vec_t;
  typedef struct {logic [15:0] q; logic [7:0] r; logic d; int lat;} exp_t;
  vec_t vt[7];
  exp_t sb[$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rexp(input logic [7:0] rv);
`ifdef LIB_DIV_REM_EN
    return rv;
`else
    return 8'h00;
`endif
  endfunction

  task automatic run(input logic [15:0] av, input logic [7:0] bv, input logic [15:0] eq,
                     input logic [7:0] er, input logic ed, input int hold);
    exp_t e;
    int n;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    sb.push_back('{eq, rexp(er), ed, ed ? 0 : Na + 1});
    @(posedge clk); #1;
    a = ~av; b = ~bv;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("q", q, e.q);
    chk("r", r, e.r);
    chk("dbz", dbz, e.d);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_q", q, e.q);
      chk("hold_r", r, e.r);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("handoff_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0] rb;
    int ai, bi;
    vt[0] = '{16'd100,   8'd7,    16'd14,    8'd2,    1'b0, 5};
    vt[1] = '{-16'sd100, 8'd7,    -16'sd14,  -8'sd2,  1'b0, 0};
    vt[2] = '{16'd100,   -8'sd7,  -16'sd14,  8'd2,    1'b0, 0};
    vt[3] = '{-16'sd100, -8'sd7,  16'd14,    -8'sd2,  1'b0, 0};
    vt[4] = '{16'h8000,  8'hFF,   16'h8000,  8'd0,    1'b0, 0};
    vt[5] = '{16'd32767, 8'h80,   -16'sd255, 8'd127,  1'b0, 0};
    vt[6] = '{16'd1234,  8'd0,    16'd0,     8'd0,    1'b1, 2};
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].d, vt[i].hold);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i == 7) rb = 8'd3;
      ai = int'($signed(ra));
      bi = int'($signed(rb));
      if (bi == 0) run(ra, rb, 16'd0, 8'd0, 1'b1, 0);
      else run(ra, rb, 16'(ai / bi), 8'(ai % bi), 1'b0, 0);
    end
    @(negedge clk);
    a = 16'd100; b = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_q", q, 0);
    chk("midrst_r", r, 0);
    chk("midrst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lib_div_seq.md
LIB_DIV_SEQ -- requirements
Module: lib_div_seq

Interface
REQ-001 SHALL have parameter Na, default 16, giving the dividend and quotient bit width.
REQ-002 SHALL have parameter Nb, default 8, giving the divisor and remainder bit width; Nb <= Na.
REQ-003 SHALL have port clk, input, width 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, width 1, the asynchronous active-low reset.
REQ-005 SHALL have port a, input, width Na, the two's-complement dividend.
REQ-006 SHALL have port b, input, width Nb, the two's-complement divisor.
REQ-007 SHALL have port in_valid, input, width 1, asserted when operands a and b are valid.
REQ-008 SHALL have port in_ready, output, width 1, asserted when the block can accept operands.
REQ-009 SHALL have port q, output, width Na, the two's-complement quotient.
REQ-010 SHALL have port r, output, width Nb, the two's-complement remainder.
REQ-011 SHALL have port dbz, output, width 1, the divide-by-zero flag, valid while out_valid is high.
REQ-012 SHALL have port out_valid, output, width 1, asserted when q, r and dbz hold a result.
REQ-013 SHALL have port out_ready, input, width 1, asserted when the consumer accepts the result.

Function
REQ-014 SHALL implement the states IDLE, CALC, FIX and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept operands on the edge where in_valid && in_ready are both high.
- Latches |a| as Na-bit unsigned (-2^(Na-1) maps to 2^(Na-1)).
- Latches |b| as Nb-bit unsigned.
- Latches sign_q = a[Na-1]^b[Nb-1] and sign_r = a[Na-1].
REQ-016 On acceptance with b != 0, SHALL go to CALC and clear the iteration counter.
REQ-017 On acceptance with b == 0, SHALL go directly to DONE with dbz=1, q=0, r=0, so out_valid is high after the accepting edge.
REQ-018 In CALC, SHALL perform one restoring-division step per clock, MSB first, for exactly Na steps; the partial remainder is Nb+1 bits wide.
REQ-019 After the Na-th CALC step, SHALL go to FIX and apply the sign correction on the FIX edge.
- q = sign_q ? two's-complement negation of the magnitude : magnitude.
- r = sign_r ? two's-complement negation of the magnitude : magnitude.
- dbz = 0.
REQ-020 With acceptance at edge k and b != 0, out_valid SHALL first be high after edge k+Na+1.
REQ-021 Division SHALL truncate toward zero; the remainder SHALL take the dividend's sign and satisfy a = q*b + r.
REQ-022 The case a = -2^(Na-1), b = -1 SHALL wrap to q = -2^(Na-1), r = 0, with no flag.
REQ-023 In DONE, q, r, dbz and out_valid SHALL hold stable until out_ready is high.
REQ-024 On a DONE edge with out_ready high, SHALL return to IDLE, with in_ready high in the next cycle; a new operand is never accepted in the same cycle as result handoff.
REQ-025 in_valid SHALL be ignored outside IDLE, and operand changes during CALC, FIX or DONE SHALL not affect the result.
REQ-026 q, r and dbz SHALL be registered outputs and SHALL stay at their last values outside DONE.

Reset
REQ-027 Asserting rst_n low at any time, including mid-CALC, SHALL immediately force:
- state to IDLE;
- q, r and dbz to 0;
- out_valid to 0 and in_ready to 1;
- the counter and partial remainder to 0.
REQ-028 After rst_n deasserts, the first operand SHALL be acceptable on the first rising edge.

Configuration
REQ-029 SHALL use macro LIB_DIV_REM_EN to compile in the remainder output.
- Defined: r behaves as specified in REQ-019, REQ-021 and REQ-022.
- Undefined: r is held at 0 constantly, with no remainder sign-correction logic; quotient behaviour and latency are unchanged.

Verification
REQ-030 The bench SHALL use Na=16, Nb=8 with LIB_DIV_REM_EN defined, and cover:
- a=100, b=7 -> q=14, r=2, dbz=0; out_valid rises 17 edges after acceptance.
- a=-100, b=7 -> q=-14, r=-2; a=100, b=-7 -> q=-14, r=2; a=-100, b=-7 -> q=14, r=-2.
- a=-32768, b=-1 -> q=-32768, r=0, dbz=0; a=32767, b=-128 -> q=-255, r=127.
- a=1234, b=0 -> dbz=1, q=0, r=0, out_valid high one edge after acceptance.
- out_ready held low 5 cycles in DONE -> q/r/out_valid stable and in_ready=0 with in_valid=1; out_ready=1 -> IDLE next edge.
- rst_n pulsed low at CALC step 8 -> out_valid=0, in_ready=1, q=r=0 immediately; next operand 50/5 -> q=10, r=0.
